accu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit accumulator ALU. Fetches 8-bit instructions from a synchronous program memory and drives the register-file read/write strobes. Also drives the ALU's `alu_ce`, `cy_ce` and `opcode` inputs, and sequences jumps, conditional branches and halt. Sits between program memory, register file and ALU as the sole control source of the datapath.

---
 rtl/accu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_accu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator ALU datapath.
// Optional feature: define ACCU_SEQ_BRANCH_EN to implement JZ (op A) / JNZ (op B).

`ifndef ACCU_OPCODE_WIDTH
`define ACCU_OPCODE_WIDTH 4
`endif
`ifndef ACCU_OP_NOP
`define ACCU_OP_NOP 4'h0
`define ACCU_OP_ADD 4'h1
`define ACCU_OP_SUB 4'h2
`define ACCU_OP_LD  4'h3
`define ACCU_OP_AND 4'h4
`define ACCU_OP_OR  4'h5
`define ACCU_OP_XOR 4'h6
`define ACCU_OP_NOT 4'h7
`endif

module accu_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter int OPCODE_WIDTH = `ACCU_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [PC_WIDTH-1:0]     pm_addr,
    input  logic [7:0]              pm_data,
    input  logic [7:0]              acc,
    output logic [3:0]              rf_addr,
    output logic                    rf_we,
    output logic                    alu_ce,
    output logic                    cy_ce,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    busy,
    output logic                    halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_OPND   = 3'd4,
        S_JUMP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t                  state_r;
    logic [PC_WIDTH-1:0]     pc_r;
    logic [7:0]              ir_r;
    logic [OPCODE_WIDTH-1:0] opcode_r;
    logic                    alu_ce_r;
    logic                    cy_ce_r;
    logic                    rf_we_r;
    logic                    busy_r;
    logic                    halted_r;
    logic                    acc_zero_s;

    function automatic logic [OPCODE_WIDTH-1:0] map_op(input logic [3:0] op);
        case (op)
            4'h1:    map_op = OPCODE_WIDTH'(`ACCU_OP_ADD);
            4'h2:    map_op = OPCODE_WIDTH'(`ACCU_OP_SUB);
            4'h3:    map_op = OPCODE_WIDTH'(`ACCU_OP_LD);
            4'h4:    map_op = OPCODE_WIDTH'(`ACCU_OP_AND);
            4'h5:    map_op = OPCODE_WIDTH'(`ACCU_OP_OR);
            4'h6:    map_op = OPCODE_WIDTH'(`ACCU_OP_XOR);
            4'h7:    map_op = OPCODE_WIDTH'(`ACCU_OP_NOT);
            default: map_op = OPCODE_WIDTH'(`ACCU_OP_NOP);
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        is_alu_op = (op >= 4'h1) && (op <= 4'h7);
    endfunction

    function automatic logic is_two_byte(input logic [3:0] op);
`ifdef ACCU_SEQ_BRANCH_EN
        is_two_byte = (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
`else
        is_two_byte = (op == 4'h9);
`endif
    endfunction

    // Only two-byte ops ever reach JUMP, so the JZ/JNZ terms are inert when branches are compiled out.
    function automatic logic branch_taken(input logic [3:0] op, input logic is_zero);
        case (op)
            4'h9:    branch_taken = 1'b1;
            4'hA:    branch_taken = is_zero;
            4'hB:    branch_taken = !is_zero;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    assign acc_zero_s = (acc == 8'h00);

    // Controller state machine; strobes default low so they are one-cycle pulses in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            pc_r     <= {PC_WIDTH{1'b0}};
            ir_r     <= 8'h00;
            opcode_r <= {OPCODE_WIDTH{1'b0}};
            alu_ce_r <= 1'b0;
            cy_ce_r  <= 1'b0;
            rf_we_r  <= 1'b0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            alu_ce_r <= 1'b0;
            cy_ce_r  <= 1'b0;
            rf_we_r  <= 1'b0;
            case (state_r)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_r     <= {PC_WIDTH{1'b0}};
                        state_r  <= S_FETCH;
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_FETCH: begin
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    ir_r     <= pm_data;
                    pc_r     <= pc_r + PC_WIDTH'(1'b1);
                    opcode_r <= map_op(pm_data[7:4]);
                    if (pm_data[7:4] == 4'hF) begin
                        state_r  <= S_HALT;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else if (is_two_byte(pm_data[7:4])) begin
                        state_r <= S_OPND;
                    end else begin
                        state_r  <= S_EXEC;
                        alu_ce_r <= is_alu_op(pm_data[7:4]);
                        cy_ce_r  <= (pm_data[7:4] == 4'h1) || (pm_data[7:4] == 4'h2);
                        rf_we_r  <= (pm_data[7:4] == 4'h8);
                    end
                end
                S_EXEC: begin
                    state_r <= S_FETCH;
                end
                S_OPND: begin
                    state_r <= S_JUMP;
                end
                S_JUMP: begin
                    if (branch_taken(ir_r[7:4], acc_zero_s)) begin
                        pc_r <= pm_data[PC_WIDTH-1:0];
                    end else begin
                        pc_r <= pc_r + PC_WIDTH'(1'b1);
                    end
                    state_r <= S_FETCH;
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign pm_addr = pc_r;
    assign rf_addr = ir_r[3:0];
    assign opcode  = opcode_r;
    assign alu_ce  = alu_ce_r;
    assign cy_ce   = cy_ce_r;
    assign rf_we   = rf_we_r;
    assign busy    = busy_r;
    assign halted  = halted_r;

endmodule

// File: tb/tb_accu_sequencer.sv
// Directed bench for accu_sequencer with a behavioural program memory, register file and ALU.
module tb_accu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic [7:0] acc;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic       alu_ce;
    logic       cy_ce;
    logic [3:0] opcode;
    logic       busy;
    logic       halted;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mem [256];
    logic [3:0] st_addr_q;
    logic [7:0] st_data_q;
    int         st_count;

    accu_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pm_addr (pm_addr),
        .pm_data (pm_data),
        .acc     (acc),
        .rf_addr (rf_addr),
        .rf_we   (rf_we),
        .alu_ce  (alu_ce),
        .cy_ce   (cy_ce),
        .opcode  (opcode),
        .busy    (busy),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid one cycle after the address.
    always @(posedge clk) pm_data <= mem[pm_addr];

    function automatic logic [7:0] rf_val(input logic [3:0] a);
        if (a == 4'd1) return 8'd5;
        else if (a == 4'd2) return 8'd3;
        else return 8'd0;
    endfunction

    // ALU and register-file write model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 8'h00;
            st_count  <= 0;
            st_addr_q <= 4'h0;
            st_data_q <= 8'h00;
        end else begin
            if (alu_ce) begin
                case (opcode)
                    4'h1:    acc <= acc + rf_val(rf_addr);
                    4'h2:    acc <= acc - rf_val(rf_addr);
                    4'h3:    acc <= rf_val(rf_addr);
                    4'h4:    acc <= acc & rf_val(rf_addr);
                    4'h5:    acc <= acc | rf_val(rf_addr);
                    4'h6:    acc <= acc ^ rf_val(rf_addr);
                    4'h7:    acc <= ~acc;
                    default: acc <= acc;
                endcase
            end
            if (rf_we) begin
                st_addr_q <= rf_addr;
                st_data_q <= acc;
                st_count  <= st_count + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start for one edge; returns in cycle 1 (FETCH of address 0).
    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();

        // Reset state
        do_reset();
        cycles(2);
        chk("rst_pm_addr", pm_addr, 8'h00);
        chk("rst_rf_addr", rf_addr, 4'h0);
        chk("rst_opcode",  opcode,  4'h0);
        chk("rst_alu_ce",  alu_ce,  1'b0);
        chk("rst_cy_ce",   cy_ce,   1'b0);
        chk("rst_rf_we",   rf_we,   1'b0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_halted",  halted,  1'b0);

        // ALU sequence: LD r1, ADD r2, ST r5, HALT
        mem[0] = 8'h31; mem[1] = 8'h12; mem[2] = 8'h85; mem[3] = 8'hF0;
        do_reset();
        go();
        chk("seq_c1_pm_addr", pm_addr, 8'h00);
        chk("seq_c1_busy",    busy,    1'b1);
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("seq_c%0d_alu_ce", c), alu_ce, (c == 3 || c == 6));
            chk($sformatf("seq_c%0d_cy_ce", c),  cy_ce,  (c == 6));
            chk($sformatf("seq_c%0d_rf_we", c),  rf_we,  (c == 9));
            if (c == 3) chk("seq_ld_opcode", opcode, 4'h3);
            if (c == 6) chk("seq_add_opcode", opcode, 4'h1);
            if (c == 9) begin
                chk("seq_st_rf_addr", rf_addr, 4'h5);
                chk("seq_st_acc",     acc,     8'h08);
            end
            if (c == 11) chk("seq_c11_halted", halted, 1'b0);
            if (c < 12) cycles(1);
        end
        chk("seq_halted",   halted,    1'b1);
        chk("seq_busy",     busy,      1'b0);
        chk("seq_st_count", st_count,  1);
        chk("seq_st_data",  st_data_q, 8'h08);
        chk("seq_st_addr",  st_addr_q, 4'h5);
        cycles(3);
        chk("halt_hold",        halted, 1'b1);
        chk("halt_alu_ce_low",  alu_ce, 1'b0);

        // Start in HALT restarts at 0; start while busy is ignored
        go();
        chk("restart_pm_addr", pm_addr, 8'h00);
        chk("restart_busy",    busy,    1'b1);
        chk("restart_halted",  halted,  1'b0);
        cycles(2);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        chk("busy_start_exec_pm_addr", pm_addr, 8'h01);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        chk("busy_start_fetch_pm_addr", pm_addr, 8'h01);
        chk("busy_start_busy",          busy,    1'b1);

        // Reset during EXEC of ADD
        clear_mem();
        mem[0] = 8'h12; mem[1] = 8'hF0;
        do_reset();
        go();
        cycles(2);
        chk("rstx_pre_alu_ce", alu_ce, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstx_alu_ce",  alu_ce,  1'b0);
        chk("rstx_cy_ce",   cy_ce,   1'b0);
        chk("rstx_busy",    busy,    1'b0);
        chk("rstx_rf_addr", rf_addr, 4'h0);
        chk("rstx_opcode",  opcode,  4'h0);
        cycles(1);
        rst = 1'b0;
        cycles(2);
        chk("rstx_idle_pm_addr", pm_addr, 8'h00);
        chk("rstx_idle_busy",    busy,    1'b0);
        chk("rstx_idle_alu_ce",  alu_ce,  1'b0);
        chk("rstx_acc",          acc,     8'h00);

        // JMP 0xFF with NOP at 0xFF wraps to 0x00
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'hFF; mem[255] = 8'h00;
        do_reset();
        go();
        cycles(2);
        chk("wrap_opnd_pm_addr", pm_addr, 8'h01);
        cycles(2);
        chk("wrap_target_pm_addr", pm_addr, 8'hFF);
        cycles(3);
        chk("wrap_next_pm_addr", pm_addr, 8'h00);
        chk("wrap_busy",         busy,    1'b1);

        // JMP at 0xFE takes its target from 0xFF
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'hFE; mem[254] = 8'h90; mem[255] = 8'h20; mem[32] = 8'hF0;
        do_reset();
        go();
        cycles(4);
        chk("jfe_fetch_pm_addr", pm_addr, 8'hFE);
        cycles(2);
        chk("jfe_opnd_pm_addr", pm_addr, 8'hFF);
        cycles(2);
        chk("jfe_target_pm_addr", pm_addr, 8'h20);
        cycles(2);
        chk("jfe_halted", halted, 1'b1);

`ifdef ACCU_SEQ_BRANCH_EN
        // JZ taken with acc == 0
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h10; mem[16] = 8'hF0;
        do_reset();
        go();
        cycles(3);
        chk("jz_jump_busy", busy, 1'b1);
        cycles(1);
        chk("jz_target_pm_addr", pm_addr, 8'h10);
        cycles(2);
        chk("jz_halted", halted, 1'b1);

        // JNZ not taken with acc == 0 falls through to pc+2
        clear_mem();
        mem[0] = 8'hB0; mem[1] = 8'h10; mem[2] = 8'hF0;
        do_reset();
        go();
        cycles(4);
        chk("jnz_fall_pm_addr", pm_addr, 8'h02);
        cycles(2);
        chk("jnz_halted", halted, 1'b1);
`else
        // A0 decodes as a NOP; the following F0 is executed as HALT
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hF0;
        do_reset();
        go();
        cycles(2);
        chk("nob_exec_alu_ce", alu_ce, 1'b0);
        chk("nob_exec_busy",   busy,   1'b1);
        cycles(2);
        chk("nob_c5_halted", halted, 1'b0);
        cycles(1);
        chk("nob_c6_halted",  halted,  1'b1);
        chk("nob_c6_pm_addr", pm_addr, 8'h02);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
